axi_mem_responder: RTL and testbench



---
 rtl/axi_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: single-beat and INCR bursts from an internal SRAM.
// Define AXI_MEM_RESP_DELAY_EN to insert RESP_DELAY wait cycles before first R / B.
package ariane_axi;
    localparam int unsigned IdWidth = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
        logic [5:0]         atop;
    } aw_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
    } ar_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        data;
        logic [1:0]         resp;
        logic               last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_mem_responder
    import ariane_axi::*;
#(
    parameter int unsigned NUM_WORDS  = 1024,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int unsigned RESP_DELAY = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  ariane_axi::req_t  axi_req_i,
    output ariane_axi::resp_t axi_resp_o
);
    localparam int unsigned IdxW = $clog2(NUM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_BEAT,
        WR_DATA,
        WR_RESP
    } state_t;

    state_t             state;
    logic [IdWidth-1:0] id_q;
    logic [63:0]        addr_q;
    logic [7:0]         len_q;
    logic [7:0]         beat_q;
    logic [1:0]         burst_q;
    logic               dec_err_q;
    logic               slv_err_q;
    logic               last_wr_q;
    logic [63:0]        r_data_q;
    logic [1:0]         r_resp_q;
    logic               r_last_q;
    logic               b_valid_q;
    logic [1:0]         b_resp_q;

    logic [63:0] mem [NUM_WORDS];

    logic [63:0]     off;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic [63:0]     addr_next;
    logic            idle;
    logic            ar_grant;
    logic            aw_grant;
    logic            w_hs;
    logic            fetch_go;
    logic            unused;

    assign off       = addr_q - BASE_ADDR;
    assign in_range  = (off[63:IdxW+3] == '0);
    assign idx       = off[IdxW+2:3];
    assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + 64'd8;

    // A tie goes to whichever channel was not served last.
    assign idle     = rst_ni && (state == IDLE);
    assign ar_grant = idle && axi_req_i.ar_valid
                      && (!axi_req_i.aw_valid || last_wr_q);
    assign aw_grant = idle && axi_req_i.aw_valid && !ar_grant;
    assign w_hs     = (state == WR_DATA) && axi_req_i.w_valid;

`ifdef AXI_MEM_RESP_DELAY_EN
    logic [7:0] dly_q;
    assign fetch_go = (dly_q == 8'd0);
    assign unused   = ^{axi_req_i.aw.size, axi_req_i.ar.size, off[2:0]};
`else
    assign fetch_go = 1'b1;
    assign unused   = ^{axi_req_i.aw.size, axi_req_i.ar.size, off[2:0],
                        RESP_DELAY == 0};
`endif

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_grant;
        axi_resp_o.ar_ready = ar_grant;
        axi_resp_o.w_ready  = (state == WR_DATA);
        axi_resp_o.b_valid  = b_valid_q;
        axi_resp_o.b.id     = id_q;
        axi_resp_o.b.resp   = b_resp_q;
        axi_resp_o.r_valid  = (state == RD_BEAT);
        axi_resp_o.r.id     = id_q;
        axi_resp_o.r.data   = r_data_q;
        axi_resp_o.r.resp   = r_resp_q;
        axi_resp_o.r.last   = r_last_q;
    end

    always_ff @(posedge clk_i) begin
        if (w_hs && in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (axi_req_i.w.strb[i]) begin
                    mem[idx][8*i +: 8] <= axi_req_i.w.data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            burst_q   <= '0;
            dec_err_q <= 1'b0;
            slv_err_q <= 1'b0;
            last_wr_q <= 1'b1;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            r_last_q  <= 1'b0;
            b_valid_q <= 1'b0;
            b_resp_q  <= '0;
`ifdef AXI_MEM_RESP_DELAY_EN
            dly_q     <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (ar_grant) begin
                        id_q      <= axi_req_i.ar.id;
                        addr_q    <= axi_req_i.ar.addr;
                        len_q     <= axi_req_i.ar.len;
                        burst_q   <= axi_req_i.ar.burst;
                        beat_q    <= '0;
                        last_wr_q <= 1'b0;
                        state     <= RD_FETCH;
`ifdef AXI_MEM_RESP_DELAY_EN
                        dly_q     <= 8'(RESP_DELAY);
`endif
                    end else if (aw_grant) begin
                        id_q      <= axi_req_i.aw.id;
                        addr_q    <= axi_req_i.aw.addr;
                        len_q     <= axi_req_i.aw.len;
                        burst_q   <= axi_req_i.aw.burst;
                        beat_q    <= '0;
                        dec_err_q <= 1'b0;
                        slv_err_q <= (axi_req_i.aw.atop != '0)
                                     || axi_req_i.aw.burst[1];
                        last_wr_q <= 1'b1;
                        state     <= WR_DATA;
                    end
                end
                RD_FETCH: begin
`ifdef AXI_MEM_RESP_DELAY_EN
                    if (!fetch_go) dly_q <= dly_q - 8'd1;
`endif
                    if (fetch_go) begin
                        r_last_q <= (beat_q == len_q);
                        if (burst_q[1]) begin
                            r_data_q <= '0;
                            r_resp_q <= RESP_SLVERR;
                        end else if (!in_range) begin
                            r_data_q <= '0;
                            r_resp_q <= RESP_DECERR;
                        end else begin
                            r_data_q <= mem[idx];
                            r_resp_q <= RESP_OKAY;
                        end
                        state <= RD_BEAT;
                    end
                end
                RD_BEAT: begin
                    if (axi_req_i.r_ready) begin
                        if (r_last_q) begin
                            state <= IDLE;
                        end else begin
                            addr_q <= addr_next;
                            beat_q <= beat_q + 8'd1;
                            state  <= RD_FETCH;
                        end
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        addr_q <= addr_next;
                        beat_q <= beat_q + 8'd1;
                        if (!in_range) dec_err_q <= 1'b1;
                        if (axi_req_i.w.last) begin
                            if (dec_err_q || !in_range) begin
                                b_resp_q <= RESP_DECERR;
                            end else if (slv_err_q || beat_q != len_q) begin
                                b_resp_q <= RESP_SLVERR;
                            end else begin
                                b_resp_q <= RESP_OKAY;
                            end
`ifdef AXI_MEM_RESP_DELAY_EN
                            b_valid_q <= (RESP_DELAY == 0);
                            dly_q     <= 8'(RESP_DELAY);
`else
                            b_valid_q <= 1'b1;
`endif
                            state <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
`ifdef AXI_MEM_RESP_DELAY_EN
                    if (!b_valid_q) begin
                        dly_q <= dly_q - 8'd1;
                        if (dly_q == 8'd1) b_valid_q <= 1'b1;
                    end
`endif
                    if (b_valid_q && axi_req_i.b_ready) begin
                        b_valid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: reads, writes, errors, arbitration, reset.
module tb_axi_mem_responder;
    import ariane_axi::*;

    localparam logic [63:0] A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] B = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] C = 64'hCAFE_F00D_DEAD_BEEF;
    localparam logic [63:0] D = 64'h1111_2222_3333_4444;
    localparam logic [63:0] E = 64'h5555_6666_7777_8888;

    logic  clk;
    logic  rst_ni;
    req_t  req;
    resp_t resp;
    int    passed;
    int    total;

    axi_mem_responder dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .axi_req_i (req),
        .axi_resp_o(resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [63:0] a, input logic [7:0] l,
                           input logic [1:0] bu, input logic [3:0] id,
                           input logic [5:0] atop);
        int n;
        n = 0;
        req.aw.id    = id;
        req.aw.addr  = a;
        req.aw.len   = l;
        req.aw.size  = 3'd3;
        req.aw.burst = bu;
        req.aw.atop  = atop;
        req.aw_valid = 1'b1;
        #1;
        while (!resp.aw_ready && n < 50) begin tick(); n++; end
        if (n == 50) begin
            total++;
            $display("FAIL aw_timeout: aw_ready never high");
        end
        tick();
        req.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [63:0] a, input logic [7:0] l,
                           input logic [1:0] bu, input logic [3:0] id);
        int n;
        n = 0;
        req.ar.id    = id;
        req.ar.addr  = a;
        req.ar.len   = l;
        req.ar.size  = 3'd3;
        req.ar.burst = bu;
        req.ar_valid = 1'b1;
        #1;
        while (!resp.ar_ready && n < 50) begin tick(); n++; end
        if (n == 50) begin
            total++;
            $display("FAIL ar_timeout: ar_ready never high");
        end
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s,
                          input logic l);
        int n;
        n = 0;
        req.w.data  = d;
        req.w.strb  = s;
        req.w.last  = l;
        req.w_valid = 1'b1;
        #1;
        while (!resp.w_ready && n < 50) begin tick(); n++; end
        if (n == 50) begin
            total++;
            $display("FAIL w_timeout: w_ready never high");
        end
        tick();
        req.w_valid = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] rs, output logic [3:0] id,
                         output int lat);
        int n;
        n = 0;
        req.b_ready = 1'b1;
        #1;
        while (!resp.b_valid && n < 50) begin tick(); n++; end
        if (n == 50) begin
            total++;
            $display("FAIL b_timeout: b_valid never high");
        end
        rs  = resp.b.resp;
        id  = resp.b.id;
        lat = n;
        tick();
        req.b_ready = 1'b0;
    endtask

    task automatic get_r(output logic [63:0] d, output logic [1:0] rs,
                         output logic l, output logic [3:0] id,
                         output int lat);
        int n;
        n = 0;
        req.r_ready = 1'b1;
        #1;
        while (!resp.r_valid && n < 50) begin tick(); n++; end
        if (n == 50) begin
            total++;
            $display("FAIL r_timeout: r_valid never high");
        end
        d   = resp.r.data;
        rs  = resp.r.resp;
        l   = resp.r.last;
        id  = resp.r.id;
        lat = n;
        tick();
        req.r_ready = 1'b0;
    endtask

    task automatic write1(input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, output logic [1:0] rs);
        logic [3:0] id;
        int         lat;
        send_aw(a, 8'd0, BURST_INCR, 4'd0, 6'd0);
        send_w(d, s, 1'b1);
        get_b(rs, id, lat);
    endtask

    task automatic read1(input logic [63:0] a, output logic [63:0] d,
                         output logic [1:0] rs);
        logic       l;
        logic [3:0] id;
        int         lat;
        send_ar(a, 8'd0, BURST_INCR, 4'd0);
        get_r(d, rs, l, id, lat);
    endtask

    task automatic test_reset();
        req    = '0;
        rst_ni = 1'b0;
        repeat (3) tick();
        total++;
        if (resp !== '0) $display("FAIL reset_outputs: got %h want 0", resp);
        else passed++;
        rst_ni = 1'b1;
        tick();
        total++;
        if (resp !== '0) $display("FAIL post_reset_idle: got %h want 0", resp);
        else passed++;
    endtask

    task automatic test_write();
        logic [1:0] rs;
        logic [3:0] id;
        int         lat;
        send_aw(64'h8000_0000, 8'd1, BURST_INCR, 4'd1, 6'd0);
        send_w(A, 8'hFF, 1'b0);
        send_w(B, 8'hFF, 1'b1);
        get_b(rs, id, lat);
        total++;
        if (rs !== RESP_OKAY || id !== 4'd1 || lat !== 0)
            $display("FAIL wr_burst_b: resp %0d id %0d lat %0d want 0 1 0",
                     rs, id, lat);
        else passed++;
        write1(64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rs);
        write1(64'h8000_0010, 64'h1122_3344_5566_7788, 8'h0F, rs);
        total++;
        if (rs !== RESP_OKAY) $display("FAIL wr_strb_b: got %0d want 0", rs);
        else passed++;
    endtask

    task automatic test_read_burst();
        logic [63:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  id;
        int          lat;
        send_ar(64'h8000_0000, 8'd1, BURST_INCR, 4'd3);
        get_r(d, rs, l, id, lat);
        total++;
        if (d !== A || rs !== RESP_OKAY || l !== 1'b0 || id !== 4'd3 || lat !== 1)
            $display("FAIL rd_beat0: d %h rs %0d l %0d id %0d lat %0d want %h 0 0 3 1",
                     d, rs, l, id, lat, A);
        else passed++;
        get_r(d, rs, l, id, lat);
        total++;
        if (d !== B || rs !== RESP_OKAY || l !== 1'b1 || id !== 4'd3 || lat !== 1)
            $display("FAIL rd_beat1: d %h rs %0d l %0d id %0d lat %0d want %h 0 1 3 1",
                     d, rs, l, id, lat, B);
        else passed++;
        read1(64'h8000_0010, d, rs);
        total++;
        if (d !== 64'hFFFF_FFFF_5566_7788 || rs !== RESP_OKAY)
            $display("FAIL rd_strb: d %h rs %0d want ffffffff55667788 0", d, rs);
        else passed++;
        send_ar(64'h8000_0008, 8'd1, BURST_FIXED, 4'd2);
        get_r(d, rs, l, id, lat);
        get_r(d, rs, l, id, lat);
        total++;
        if (d !== B || l !== 1'b1)
            $display("FAIL rd_fixed: d %h l %0d want %h 1", d, l, B);
        else passed++;
    endtask

    task automatic test_decerr();
        logic [63:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  id;
        int          lat;
        send_ar(64'h7FFF_FFF8, 8'd1, BURST_INCR, 4'd4);
        get_r(d, rs, l, id, lat);
        total++;
        if (d !== 64'd0 || rs !== RESP_DECERR)
            $display("FAIL rd_decerr: d %h rs %0d want 0 3", d, rs);
        else passed++;
        get_r(d, rs, l, id, lat);
        total++;
        if (d !== A || rs !== RESP_OKAY || l !== 1'b1)
            $display("FAIL rd_after_decerr: d %h rs %0d l %0d want %h 0 1",
                     d, rs, l, A);
        else passed++;
        write1(64'h8000_1FF8, D, 8'hFF, rs);
        read1(64'h8000_1FF8, d, rs);
        total++;
        if (d !== D || rs !== RESP_OKAY)
            $display("FAIL last_word: d %h rs %0d want %h 0", d, rs, D);
        else passed++;
        write1(64'h8000_2000, E, 8'hFF, rs);
        total++;
        if (rs !== RESP_DECERR) $display("FAIL wr_decerr: got %0d want 3", rs);
        else passed++;
    endtask

    task automatic test_arbitration();
        logic [63:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  id;
        int          lat;
        rst_ni = 1'b0;
        req    = '0;
        tick();
        rst_ni = 1'b1;
        tick();
        req.aw.id    = 4'd5;
        req.aw.addr  = 64'h8000_0018;
        req.aw.len   = 8'd0;
        req.aw.size  = 3'd3;
        req.aw.burst = BURST_INCR;
        req.ar.id    = 4'd6;
        req.ar.addr  = 64'h8000_0000;
        req.ar.len   = 8'd0;
        req.ar.size  = 3'd3;
        req.ar.burst = BURST_INCR;
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        #1;
        total++;
        if (resp.ar_ready !== 1'b1 || resp.aw_ready !== 1'b0)
            $display("FAIL tie_first: ar_ready %0d aw_ready %0d want 1 0",
                     resp.ar_ready, resp.aw_ready);
        else passed++;
        tick();
        req.ar_valid = 1'b0;
        total++;
        if (resp.aw_ready !== 1'b0)
            $display("FAIL busy_no_aw: aw_ready %0d want 0", resp.aw_ready);
        else passed++;
        get_r(d, rs, l, id, lat);
        total++;
        if (d !== A || id !== 4'd6)
            $display("FAIL tie_read: d %h id %0d want %h 6", d, id, A);
        else passed++;
        req.ar_valid = 1'b1;
        #1;
        total++;
        if (resp.aw_ready !== 1'b1 || resp.ar_ready !== 1'b0)
            $display("FAIL tie_second: aw_ready %0d ar_ready %0d want 1 0",
                     resp.aw_ready, resp.ar_ready);
        else passed++;
        tick();
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        send_w(C, 8'hFF, 1'b1);
        get_b(rs, id, lat);
        total++;
        if (rs !== RESP_OKAY || id !== 4'd5)
            $display("FAIL tie_write_b: rs %0d id %0d want 0 5", rs, id);
        else passed++;
        read1(64'h8000_0018, d, rs);
        total++;
        if (d !== C) $display("FAIL tie_write_data: got %h want %h", d, C);
        else passed++;
    endtask

    task automatic test_short_burst();
        logic [63:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  id;
        int          lat;
        send_aw(64'h8000_0020, 8'd3, BURST_INCR, 4'd8, 6'd0);
        send_w(D, 8'hFF, 1'b0);
        send_w(E, 8'hFF, 1'b1);
        get_b(rs, id, lat);
        total++;
        if (rs !== RESP_SLVERR || id !== 4'd8)
            $display("FAIL short_b: rs %0d id %0d want 2 8", rs, id);
        else passed++;
        send_ar(64'h8000_0020, 8'd1, BURST_INCR, 4'd0);
        get_r(d, rs, l, id, lat);
        total++;
        if (d !== D) $display("FAIL short_beat0: got %h want %h", d, D);
        else passed++;
        get_r(d, rs, l, id, lat);
        total++;
        if (d !== E) $display("FAIL short_beat1: got %h want %h", d, E);
        else passed++;
    endtask

    task automatic test_atop();
        logic [63:0] d;
        logic [1:0]  rs;
        logic [3:0]  id;
        int          lat;
        send_aw(64'h8000_0030, 8'd0, BURST_INCR, 4'd9, 6'h20);
        send_w(E, 8'hFF, 1'b1);
        get_b(rs, id, lat);
        total++;
        if (rs !== RESP_SLVERR) $display("FAIL atop_b: got %0d want 2", rs);
        else passed++;
        read1(64'h8000_0030, d, rs);
        total++;
        if (d !== E) $display("FAIL atop_data: got %h want %h", d, E);
        else passed++;
    endtask

    task automatic test_stall_reset();
        int n;
        int beats;
        send_ar(64'h8000_0000, 8'd1, BURST_INCR, 4'd7);
        req.r_ready = 1'b0;
        n = 0;
        while (!resp.r_valid && n < 50) begin tick(); n++; end
        if (n == 50) begin
            total++;
            $display("FAIL stall_timeout: r_valid never high");
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                rst_ni = 1'b0;
                #1;
                total++;
                if (resp !== '0)
                    $display("FAIL stall_reset: got %h want 0", resp);
                else passed++;
                break;
            end
            total++;
            if (resp.r_valid !== 1'b1 || resp.r.data !== A
                || resp.r.last !== 1'b0 || resp.r.id !== 4'd7)
                $display("FAIL stall_stable%0d: v %0d d %h l %0d id %0d want 1 %h 0 7",
                         k, resp.r_valid, resp.r.data, resp.r.last,
                         resp.r.id, A);
            else passed++;
            tick();
        end
        tick();
        rst_ni = 1'b1;
        req.r_ready = 1'b1;
        req.b_ready = 1'b1;
        beats = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (resp.r_valid || resp.b_valid) beats++;
        end
        req.r_ready = 1'b0;
        req.b_ready = 1'b0;
        total++;
        if (beats !== 0)
            $display("FAIL no_beats_after_reset: got %0d want 0", beats);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_ni = 1'b0;
        req    = '0;
        test_reset();
        test_write();
        test_read_burst();
        test_decerr();
        test_arbitration();
        test_short_burst();
        test_atop();
        test_stall_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
